// File: rtl/i2c_reg_ctrl.sv
// Register-map controller for the I2C slave: pointer byte after START,
// auto-incrementing writes into a 2**PTR_W byte bank, and auto-incrementing
// transmit data for reads. Register 0 holds a read-only device ID.
module i2c_reg_ctrl #(
    parameter int unsigned PTR_W  = 4,
    parameter logic [7:0]  DEV_ID = 8'hA5,
    localparam int unsigned NREGS = 2 ** PTR_W
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 ENB,
    input  logic                 START,
    input  logic                 STOP,
    input  logic [7:0]           D,
    input  logic                 D_ready,
    input  logic                 Q_next,
    output logic [7:0]           Q,
    output logic [8*NREGS-1:0]   REG_OUT,
    output logic                 WR_STROBE,
    output logic [PTR_W-1:0]     WR_ADDR,
    output logic                 ERR
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GET_PTR = 2'd1,
        WR_DATA = 2'd2
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_inc;
    logic [7:0]       regs [NREGS];

    // Pointer plus one, wrapping naturally at NREGS
    always_comb begin
        ptr_inc = ptr + PTR_W'(1);
    end

    // Flatten the bank onto the export bus
    always_comb begin
        REG_OUT = '0;
        for (int unsigned k = 0; k < NREGS; k++) begin
            REG_OUT[8*k +: 8] = regs[k];
        end
    end

    // Protocol FSM, pointer, bank writes and registered outputs
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= IDLE;
            ptr       <= '0;
            Q         <= DEV_ID;
            WR_STROBE <= 1'b0;
            WR_ADDR   <= '0;
            ERR       <= 1'b0;
            regs[0]   <= DEV_ID;
            for (int unsigned k = 1; k < NREGS; k++) begin
                regs[k] <= 8'h00;
            end
        end else if (!ENB) begin
            WR_STROBE <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            WR_STROBE <= 1'b0;
            ERR       <= 1'b0;
            Q         <= regs[ptr];
            if (START) begin
                // START discards a coincident byte; a lone Q_next still advances
                state <= GET_PTR;
                if (Q_next && !D_ready) begin
                    ptr <= ptr_inc;
                end
            end else begin
                if (D_ready) begin
                    unique case (state)
                        GET_PTR: begin
                            ptr   <= D[PTR_W-1:0];
                            ERR   <= ((D >> PTR_W) != 8'd0);
                            state <= WR_DATA;
                        end
                        WR_DATA: begin
                            if (ptr == '0) begin
                                ERR <= 1'b1;
                            end else begin
                                regs[ptr] <= D;
                                WR_STROBE <= 1'b1;
                                WR_ADDR   <= ptr;
                            end
                            ptr <= ptr_inc;
                        end
                        default: ;
                    endcase
                end else if (Q_next) begin
                    ptr <= ptr_inc;
                end
                // STOP after the byte so the byte is still processed
                if (STOP) begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Bench for i2c_reg_ctrl: directed test-plan steps followed by random
// traffic, every cycle compared against a transaction-level model.
module tb_i2c_reg_ctrl;

    localparam int NR = 16;
    localparam int M_IDLE = 0;
    localparam int M_PTR  = 1;
    localparam int M_DATA = 2;

    logic         CLK = 1'b0;
    logic         RESET, ENB, START, STOP, D_ready, Q_next;
    logic [7:0]   D;
    logic [7:0]   Q;
    logic [127:0] REG_OUT;
    logic         WR_STROBE, ERR;
    logic [3:0]   WR_ADDR;

    int total = 0;
    int bad   = 0;

    // Reference model
    int           mbank [NR];
    int           mptr;
    int           mmode;
    logic [7:0]   e_q;
    logic         e_strobe, e_err;
    logic [3:0]   e_addr;
    logic [127:0] e_out;

    i2c_reg_ctrl #(.PTR_W(4), .DEV_ID(8'hA5)) dut (
        .CLK(CLK), .RESET(RESET), .ENB(ENB), .START(START), .STOP(STOP),
        .D(D), .D_ready(D_ready), .Q_next(Q_next), .Q(Q), .REG_OUT(REG_OUT),
        .WR_STROBE(WR_STROBE), .WR_ADDR(WR_ADDR), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, compare after the edge
    task automatic step(input bit rst, input bit st, input bit sp, input bit dr,
                        input logic [7:0] d, input bit qn, input bit en);
        RESET = !rst; START = st; STOP = sp; D_ready = dr; D = d; Q_next = qn; ENB = en;
        e_strobe = 1'b0;
        e_err    = 1'b0;
        if (rst) begin
            mbank[0] = 8'hA5;
            for (int k = 1; k < NR; k++) mbank[k] = 0;
            mptr = 0; mmode = M_IDLE; e_q = 8'hA5; e_addr = 4'd0;
        end else if (en) begin
            e_q = mbank[mptr][7:0];
            if (st) begin
                mmode = M_PTR;
                if (qn && !dr) mptr = (mptr + 1) % NR;
            end else begin
                if (dr) begin
                    if (mmode == M_PTR) begin
                        mptr  = d % NR;
                        e_err = (d >= NR);
                        mmode = M_DATA;
                    end else if (mmode == M_DATA) begin
                        if (mptr == 0) e_err = 1'b1;
                        else begin
                            mbank[mptr] = d;
                            e_strobe = 1'b1;
                            e_addr   = mptr[3:0];
                        end
                        mptr = (mptr + 1) % NR;
                    end
                end else if (qn) begin
                    mptr = (mptr + 1) % NR;
                end
                if (sp) mmode = M_IDLE;
            end
        end
        for (int k = 0; k < NR; k++) e_out[8*k +: 8] = mbank[k][7:0];
        @(posedge CLK);
        #1;
        chk("q", Q, e_q);
        chk("strobe", WR_STROBE, e_strobe);
        chk("err", ERR, e_err);
        chk("reg_out", REG_OUT, e_out);
        if (e_strobe || rst) chk("wr_addr", WR_ADDR, e_addr);
        START = 0; STOP = 0; D_ready = 0; Q_next = 0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 8'h00, 0, 1);
    endtask

    task automatic wr(input logic [7:0] d);
        step(0, 0, 0, 1, d, 0, 1);
    endtask

    initial begin
        logic [127:0] rst_img;
        RESET = 0; ENB = 0; START = 0; STOP = 0; D_ready = 0; D = 0; Q_next = 0;
        rst_img = '0;
        rst_img[7:0] = 8'hA5;

        // 1: reset values
        step(1, 0, 0, 0, 8'h00, 0, 1);
        chk("t1_q", Q, 8'hA5);
        chk("t1_bank", REG_OUT, rst_img);
        chk("t1_strobe", WR_STROBE, 1'b0);
        chk("t1_err", ERR, 1'b0);
        idle();

        // 2: pointer 3, three writes
        step(0, 1, 0, 0, 8'h00, 0, 1);
        wr(8'h03);
        wr(8'h11);
        chk("t2_addr3", WR_ADDR, 4'd3);
        wr(8'h22);
        chk("t2_addr4", WR_ADDR, 4'd4);
        wr(8'h33);
        chk("t2_addr5", WR_ADDR, 4'd5);
        step(0, 0, 1, 0, 8'h00, 0, 1);
        chk("t2_reg3", REG_OUT[31:24], 8'h11);
        chk("t2_reg4", REG_OUT[39:32], 8'h22);
        chk("t2_reg5", REG_OUT[47:40], 8'h33);
        idle();

        // 3: wrap 15 -> 0 -> 1, register 0 is read-only
        step(0, 1, 0, 0, 8'h00, 0, 1);
        wr(8'h0F);
        wr(8'hAA);
        wr(8'h5A);
        chk("t3_err0", ERR, 1'b1);
        chk("t3_nostrobe0", WR_STROBE, 1'b0);
        wr(8'hBB);
        chk("t3_reg15", REG_OUT[127:120], 8'hAA);
        chk("t3_reg0", REG_OUT[7:0], 8'hA5);
        chk("t3_reg1", REG_OUT[15:8], 8'hBB);

        // 4: set pointer, repeated START, read with Q_next
        step(0, 1, 0, 0, 8'h00, 0, 1);
        wr(8'h04);
        idle();
        chk("t4_q4", Q, 8'h22);
        step(0, 1, 0, 0, 8'h00, 0, 1);
        idle();
        chk("t4_q4_rs", Q, 8'h22);
        step(0, 0, 0, 0, 8'h00, 1, 1);
        idle();
        chk("t4_q5", Q, 8'h33);
        step(0, 0, 0, 0, 8'h00, 1, 1);
        idle();
        chk("t4_q6", Q, 8'h00);

        // 5: oversize pointer, then START colliding with a byte
        step(0, 1, 0, 0, 8'h00, 0, 1);
        wr(8'h23);
        chk("t5_err", ERR, 1'b1);
        step(0, 1, 0, 1, 8'h55, 0, 1);
        chk("t5_nostrobe", WR_STROBE, 1'b0);
        chk("t5_reg3", REG_OUT[31:24], 8'h11);
        wr(8'h07);
        wr(8'h66);
        chk("t5_reg7", REG_OUT[63:56], 8'h66);
        chk("t5_addr7", WR_ADDR, 4'd7);

        // 6: disabled byte is lost, then reset mid-write
        step(0, 1, 0, 0, 8'h00, 0, 1);
        wr(8'h08);
        step(0, 0, 0, 1, 8'h77, 0, 0);
        chk("t6_off_reg8", REG_OUT[71:64], 8'h00);
        chk("t6_off_strobe", WR_STROBE, 1'b0);
        wr(8'h12);
        chk("t6_reg8", REG_OUT[71:64], 8'h12);
        step(1, 0, 0, 1, 8'h99, 0, 1);
        chk("t6_rst_bank", REG_OUT, rst_img);
        chk("t6_rst_q", Q, 8'hA5);
        idle();

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            bit rst, st, sp, dr, qn, en;
            logic [7:0] d;
            rst = ($urandom_range(0, 99) == 0);
            st  = ($urandom_range(0, 11) == 0);
            sp  = ($urandom_range(0, 15) == 0);
            dr  = ($urandom_range(0, 2) == 0);
            qn  = ($urandom_range(0, 4) == 0);
            en  = ($urandom_range(0, 9) != 0);
            d   = 8'($urandom);
            if ($urandom_range(0, 3) != 0) d[7:4] = 4'h0;
            step(rst, st, sp, dr, d, qn, en);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
